// File: rtl/fifo_word_packer_if.sv
// Word-stream port of fifo_word_packer: packed little-endian word, valid byte
// count and a valid/ready handshake.
interface fifo_word_packer_if #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 4
);
   logic [DATA_W*BYTES_PER_WORD-1:0]       m_data;
   logic [$clog2(BYTES_PER_WORD+1)-1:0]    m_bytes;
   logic                                   m_valid;
   logic                                   m_ready;

   modport master (
      output m_data,
      output m_bytes,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_bytes,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a sync FIFO (1-cycle read latency) and packs them little-endian
// into words. Optional idle auto-flush is enabled by defining FIFO_PACK_TIMEOUT_EN.
module fifo_word_packer #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT        = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_read,
   input  logic              flush,
   fifo_word_packer_if.master m
);

   localparam int WORD_W = DATA_W * BYTES_PER_WORD;
   localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
   localparam logic [CNT_W:0]   BPW_EXT = (CNT_W + 1)'(BYTES_PER_WORD);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  byte_cnt, cnt_nxt;
   logic              rd_pending;
   logic              flush_req, flush_nxt;
   logic [WORD_W-1:0] asm_q, asm_nxt;
   logic [WORD_W-1:0] data_q, data_nxt;
   logic [CNT_W-1:0]  bytes_q, bytes_nxt;
   logic              valid_q, valid_nxt;
   logic              capture;
   logic              room;
   logic              timeout_hit;

   // Bytes already requested count against the word, so an in-flight read
   // never overruns the last lane.
   assign room      = ({1'b0, byte_cnt} + {{CNT_W{1'b0}}, rd_pending}) < BPW_EXT;
   assign capture   = (state == FILL) && rd_pending;
   assign fifo_read = !reset && (state == FILL) && !fifo_empty && !flush_req &&
                      !timeout_hit && room;

`ifdef FIFO_PACK_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_run;

   // The TIMEOUT-th idle cycle itself triggers the flush, so the word leaves
   // TIMEOUT cycles after the last capture.
   assign idle_run    = (state == FILL) && (byte_cnt != '0) && !rd_pending;
   assign timeout_hit = idle_run && (idle_cnt == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset || !idle_run || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = byte_cnt;
      flush_nxt = flush_req;
      asm_nxt   = asm_q;
      data_nxt  = data_q;
      bytes_nxt = bytes_q;
      valid_nxt = valid_q;

      unique case (state)
         FILL: begin
            if (flush) begin
               flush_nxt = 1'b1;
            end
            if (capture) begin
               for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                  if (byte_cnt == CNT_W'(i)) begin
                     asm_nxt[i*DATA_W +: DATA_W] = fifo_dout;
                  end
               end
               cnt_nxt = byte_cnt + 1'b1;
            end

            // A full word takes priority over any flush raised in the same cycle.
            if (capture && (byte_cnt == CNT_LAST)) begin
               state_nxt = HOLD;
               valid_nxt = 1'b1;
               data_nxt  = asm_nxt;
               bytes_nxt = CNT_FULL;
               asm_nxt   = '0;
               flush_nxt = 1'b0;
            end else if ((flush_req || timeout_hit) && !rd_pending) begin
               if (byte_cnt != '0) begin
                  state_nxt = HOLD;
                  valid_nxt = 1'b1;
                  data_nxt  = asm_q;
                  bytes_nxt = byte_cnt;
                  asm_nxt   = '0;
                  flush_nxt = 1'b0;
               end else begin
                  flush_nxt = flush;
               end
            end
         end

         HOLD: begin
            if (valid_q && m.m_ready) begin
               state_nxt = FILL;
               valid_nxt = 1'b0;
               data_nxt  = '0;
               bytes_nxt = '0;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL;
         byte_cnt   <= '0;
         rd_pending <= 1'b0;
         flush_req  <= 1'b0;
         asm_q      <= '0;
         data_q     <= '0;
         bytes_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_cnt   <= cnt_nxt;
         rd_pending <= fifo_read;
         flush_req  <= flush_nxt;
         asm_q      <= asm_nxt;
         data_q     <= data_nxt;
         bytes_q    <= bytes_nxt;
         valid_q    <= valid_nxt;
      end
   end

   assign m.m_data  = data_q;
   assign m.m_bytes = bytes_q;
   assign m.m_valid = valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a byte-stream model builds the expected
// words, and every post-reset cycle is compared against it.
module tb_fifo_word_packer;

   localparam int DW  = 8;
   localparam int BPW = 4;
   localparam int TO  = 15;
   localparam int WW  = DW * BPW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fifo_empty;
   logic          fifo_read;
   logic          flush = 1'b0;
   logic          hide_empty = 1'b0;
   logic [DW-1:0] fifo_dout;

   // Simple sync FIFO model: pop is registered, data appears one cycle later.
   logic [7:0] mem [0:255];
   int         wr_count = 0;
   int         rd_count = 0;

   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              first_read, last_read, first_valid;
   int              read_cycles, valid_cycles;
   int              accepted = 0;
   logic [WW-1:0]   last_word = '0;
   int              last_bytes = 0;
   logic [7:0]      model_q [$];
   logic [WW-1:0]   exp_d [$];
   int              exp_n [$];

   fifo_word_packer_if #(.DATA_W(DW), .BYTES_PER_WORD(BPW)) intf ();

   fifo_word_packer #(.DATA_W(DW), .BYTES_PER_WORD(BPW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_read  (fifo_read),
      .flush      (flush),
      .m          (intf)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_count == rd_count) || hide_empty;

   always @(posedge clk) begin
      if (reset) begin
         rd_count  <= wr_count;
         fifo_dout <= '0;
      end else if (fifo_read && (wr_count != rd_count)) begin
         fifo_dout <= mem[rd_count % 256];
         rd_count  <= rd_count + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic compare_cycle();
      cyc++;
      if (fifo_read) begin
         read_cycles++;
         if (first_read < 0) first_read = cyc;
         last_read = cyc;
         chk("read_while_empty", 64'(fifo_empty), 64'(0));
      end
      if (intf.m_valid) begin
         valid_cycles++;
         if (first_valid < 0) first_valid = cyc;
         chk("read_in_hold", 64'(fifo_read), 64'(0));
         if (exp_d.size() == 0) begin
            chk("unexpected_word_valid", 64'(intf.m_valid), 64'(0));
         end else begin
            chk("word_data", 64'(intf.m_data), 64'(exp_d[0]));
            chk("word_bytes", 64'(intf.m_bytes), 64'(exp_n[0]));
            if (intf.m_ready) begin
               last_word  = intf.m_data;
               last_bytes = int'(intf.m_bytes);
               void'(exp_d.pop_front());
               void'(exp_n.pop_front());
               accepted++;
            end
         end
      end else begin
         chk("idle_data", 64'(intf.m_data), 64'(0));
         chk("idle_bytes", 64'(intf.m_bytes), 64'(0));
      end
   endtask

   // Sample at the falling edge, then return just after the rising edge so
   // stimulus changes are visible for a whole cycle before the next sample.
   task automatic tick();
      @(negedge clk);
      if (!reset) compare_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      first_read   = -1;
      last_read    = -1;
      first_valid  = -1;
      read_cycles  = 0;
      valid_cycles = 0;
   endtask

   task automatic raw_push(input logic [7:0] b);
      mem[wr_count % 256] = b;
      wr_count++;
   endtask

   task automatic push(input logic [7:0] b);
      raw_push(b);
      model_q.push_back(b);
   endtask

   task automatic expect_take(input int n);
      logic [WW-1:0] w;
      w = '0;
      for (int i = 0; i < n; i++) begin
         w = w | (WW'(model_q.pop_front()) << (8 * i));
      end
      exp_d.push_back(w);
      exp_n.push_back(n);
   endtask

   task automatic wait_accept(input int target, input int budget);
      int k;
      k = 0;
      while (accepted < target && k < budget) begin
         tick();
         k++;
      end
      chk("accept_within_budget", 64'(accepted), 64'(target));
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      int base;
      int k;
      intf.m_ready = 1'b0;
      clear_stats();
      @(posedge clk);
      #1;

      // 1: reset holds outputs low even with data available
      tick();
      tick();
      raw_push(8'hEE);
      #1;
      chk("rst_fifo_read", 64'(fifo_read), 64'(0));
      chk("rst_m_valid", 64'(intf.m_valid), 64'(0));
      chk("rst_m_data", 64'(intf.m_data), 64'(0));
      chk("rst_m_bytes", 64'(intf.m_bytes), 64'(0));
      tick();
      reset = 1'b0;
      tick();
      tick();

      // 2: one word, ready high
      intf.m_ready = 1'b1;
      clear_stats();
      base = accepted;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      expect_take(4);
      wait_accept(base + 1, 20);
      repeat (3) tick();
      chk("t2_read_cycles", 64'(read_cycles), 64'(4));
      chk("t2_read_back_to_back", 64'(last_read - first_read), 64'(3));
      chk("t2_latency", 64'(first_valid - first_read), 64'(BPW + 1));
      chk("t2_valid_cycles", 64'(valid_cycles), 64'(1));
      chk("t2_word", 64'(last_word), 64'(32'h44332211));
      chk("t2_bytes", 64'(last_bytes), 64'(4));

      // 3: backpressure holds the first word, reads stop
      intf.m_ready = 1'b0;
      clear_stats();
      base = accepted;
      for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
      expect_take(4);
      expect_take(4);
      k = 0;
      while (!intf.m_valid && k < 30) begin
         tick();
         k++;
      end
      repeat (10) tick();
      chk("t3_hold_data", 64'(intf.m_data), 64'(32'h44332211));
      chk("t3_hold_valid_cycles", 64'(valid_cycles), 64'(10));
      chk("t3_reads_before_accept", 64'(read_cycles), 64'(4));
      intf.m_ready = 1'b1;
      wait_accept(base + 2, 30);
      chk("t3_second_word", 64'(last_word), 64'(32'h88776655));
      chk("t3_total_reads", 64'(read_cycles), 64'(8));

      // 4: partial flush, then flush with nothing collected
      clear_stats();
      base = accepted;
      push(8'hAA); push(8'hBB);
      expect_take(2);
      repeat (6) tick();
      pulse_flush();
      wait_accept(base + 1, 20);
      chk("t4_word", 64'(last_word), 64'(32'h0000BBAA));
      chk("t4_bytes", 64'(last_bytes), 64'(2));
      repeat (3) tick();
      clear_stats();
      pulse_flush();
      repeat (10) tick();
      chk("t4_empty_flush_no_word", 64'(valid_cycles), 64'(0));

      // 4b: flush coinciding with the last-byte capture gives one full word
      clear_stats();
      base = accepted;
      push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
      expect_take(4);
      repeat (4) tick();
      pulse_flush();
      repeat (10) tick();
      chk("t4b_words", 64'(accepted - base), 64'(1));
      chk("t4b_valid_cycles", 64'(valid_cycles), 64'(1));
      chk("t4b_bytes", 64'(last_bytes), 64'(4));
      chk("t4b_word", 64'(last_word), 64'(32'h0D0C0B0A));

      // 5: empty flag toggling every cycle
      clear_stats();
      base = accepted;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      expect_take(4);
      k = 0;
      while (accepted < base + 1 && k < 40) begin
         hide_empty = ~hide_empty;
         tick();
         k++;
      end
      hide_empty = 1'b0;
      chk("t5_accept", 64'(accepted), 64'(base + 1));
      chk("t5_word", 64'(last_word), 64'(32'h04030201));
      repeat (3) tick();

      // 6: single byte with idle timeout present or absent
      clear_stats();
      base = accepted;
      push(8'h5A);
`ifdef FIFO_PACK_TIMEOUT_EN
      expect_take(1);
      wait_accept(base + 1, 40);
      chk("t6_timeout_latency", 64'(first_valid - first_read), 64'(TO + 2));
`else
      repeat (100) tick();
      chk("t6_no_auto_flush", 64'(valid_cycles), 64'(0));
      expect_take(1);
      pulse_flush();
      wait_accept(base + 1, 20);
`endif
      chk("t6_word", 64'(last_word), 64'(32'h0000005A));
      chk("t6_bytes", 64'(last_bytes), 64'(1));
      repeat (3) tick();

      // 7: reset mid-word discards collected bytes, then normal operation resumes
      clear_stats();
      push(8'h11); push(8'h22);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_q.delete();
      pulse_flush();
      repeat (10) tick();
      chk("t7_no_word_after_reset", 64'(valid_cycles), 64'(0));
      base = accepted;
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      expect_take(4);
      wait_accept(base + 1, 20);
      chk("t7_word", 64'(last_word), 64'(32'hC4C3C2C1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
